// File: rtl/oai32_bist_pkg.sv
// rtl/oai32_bist_pkg.sv - shared types, constants and golden model for the OAI32 BIST
// Purpose: FSM state encoding, vector-space constants and the expected-ZN function
//          used by the controller to grade the cell under test.
package oai32_bist_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int NVEC  = 32;
  localparam int VEC_W = 5;

  // Golden OAI32: v = {B2, B1, A3, A2, A1}
  function automatic logic exp_zn(input logic [VEC_W-1:0] v);
    return ~((v[0] | v[1] | v[2]) & (v[3] | v[4]));
  endfunction

endpackage

// File: rtl/oai32_bist_cnt.sv
// rtl/oai32_bist_cnt.sv - settle counter and vector index for the OAI32 BIST
// Purpose: holds each vector for SETTLE_CYC cycles, then steps to the next one.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   clr_i          - force index and settle counter to zero (idle / abort)
//   en_i           - advance while a run is active
//   vec_o          - current vector index (drives the stimulus directly)
//   settle_tc_o    - this edge is the sample edge of the current vector
//   last_vec_o     - current vector is the final one
module oai32_bist_cnt
  import oai32_bist_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [VEC_W-1:0] vec_o,
  output logic             settle_tc_o,
  output logic             last_vec_o
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(NVEC - 1);

  logic [3:0]       settle_q, settle_d;
  logic [VEC_W-1:0] vec_q, vec_d;

  assign settle_tc_o = (settle_q == SETTLE_LAST);
  assign last_vec_o  = (vec_q == VEC_LAST);
  assign vec_o       = vec_q;

  // The index wraps 31 -> 0 on the final sample edge, so the stimulus
  // returns to all-zero by itself when a run completes.
  always_comb begin
    settle_d = settle_q;
    vec_d    = vec_q;
    if (clr_i) begin
      settle_d = 4'd0;
      vec_d    = '0;
    end else if (en_i) begin
      if (settle_tc_o) begin
        settle_d = 4'd0;
        vec_d    = vec_q + 1'b1;
      end else begin
        settle_d = settle_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      settle_q <= 4'd0;
      vec_q    <= '0;
    end else begin
      settle_q <= settle_d;
      vec_q    <= vec_d;
    end
  end

endmodule

// File: rtl/oai32_bist_ctrl.sv
// rtl/oai32_bist_ctrl.sv - exhaustive 32-vector BIST controller for an OAI32 cell
// Purpose: walks all 32 input combinations, compares ZN against the golden model
//          and reports mismatch count, first failing vector and pass/fail.
// Ports:
//   CLK, RN              - clock, asynchronous active-low reset
//   START, ABORT         - run request (IDLE only), immediate run termination
//   ZN                   - response of the cell under test
//   A1, A2, A3, B1, B2   - registered stimulus to the cell
//   BUSY, DONE           - run in progress, one-cycle completion pulse
//   PASS                 - last completed run had no mismatches
//   ERR_CNT, FAIL_VLD    - mismatch count, any mismatch since START
//   FIRST_FAIL           - index of the first mismatching vector
module oai32_bist_ctrl
  import oai32_bist_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic       START,
  input  logic       ABORT,
  input  logic       ZN,
  output logic       A1,
  output logic       A2,
  output logic       A3,
  output logic       B1,
  output logic       B2,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [5:0] ERR_CNT,
  output logic       FAIL_VLD,
  output logic [4:0] FIRST_FAIL
);

  state_e           state_q;
  logic             busy_q, done_q, pass_q, fail_vld_q;
  logic [5:0]       err_cnt_q, err_cnt_d;
  logic [4:0]       first_fail_q;
  logic [VEC_W-1:0] vec;
  logic             settle_tc, last_vec, mismatch;

  // Stimulus comes straight from the index register; it is held at zero
  // whenever the controller is idle.
  oai32_bist_cnt #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_cnt (
    .clk_i       (CLK),
    .rst_ni      (RN),
    .clr_i       ((state_q == IDLE) || ABORT),
    .en_i        (state_q == RUN),
    .vec_o       (vec),
    .settle_tc_o (settle_tc),
    .last_vec_o  (last_vec)
  );

  assign {B2, B1, A3, A2, A1} = vec;

  assign mismatch  = settle_tc && (ZN != exp_zn(vec));
  assign err_cnt_d = err_cnt_q + {5'd0, mismatch};

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= 6'd0;
      fail_vld_q   <= 1'b0;
      first_fail_q <= 5'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START && !ABORT) begin
            state_q      <= RUN;
            busy_q       <= 1'b1;
            pass_q       <= 1'b0;
            err_cnt_q    <= 6'd0;
            fail_vld_q   <= 1'b0;
            first_fail_q <= 5'd0;
          end
        end
        RUN: begin
          if (ABORT) begin
            // Any compare landing on this edge is dropped; results so far stay.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (settle_tc) begin
            err_cnt_q <= err_cnt_d;
            if (mismatch && !fail_vld_q) begin
              fail_vld_q   <= 1'b1;
              first_fail_q <= vec;
            end
            if (last_vec) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_cnt_d == 6'd0);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign PASS       = pass_q;
  assign ERR_CNT    = err_cnt_q;
  assign FAIL_VLD   = fail_vld_q;
  assign FIRST_FAIL = first_fail_q;

endmodule
